// File: rtl/qdec_tu_egk_fsm_if.sv
// qdec_tu_egk_fsm_if
//   Request/valid handshake between a binarization FSM and the shared CABAC
//   arithmetic bin decoder. Only one request is ever outstanding.
//
//   bin_req       FSM -> decoder  one-cycle request pulse
//   bin_ctx_addr  FSM -> decoder  context address, valid with bin_req
//   bin_bypass    FSM -> decoder  1 = bypass (EP) bin, valid with bin_req
//   bin_val       decoder -> FSM  decoded bin value
//   bin_vld       decoder -> FSM  bin_val valid, at least one cycle after bin_req
//
//   modport master : the binarization FSM side
//   modport slave  : the bin decoder side
interface qdec_tu_egk_fsm_if #(
  parameter int CTX_W = 10
);
  logic             bin_req;
  logic [CTX_W-1:0] bin_ctx_addr;
  logic             bin_bypass;
  logic             bin_val;
  logic             bin_vld;

  modport master (
    output bin_req, bin_ctx_addr, bin_bypass,
    input  bin_val, bin_vld
  );

  modport slave (
    input  bin_req, bin_ctx_addr, bin_bypass,
    output bin_val, bin_vld
  );
endinterface

// File: rtl/qdec_tu_egk_fsm.sv
// qdec_tu_egk_fsm
//   CABAC binarization sub-FSM: decodes one syntax element coded as a
//   truncated-unary prefix (context coded), an optional k-th order
//   Exp-Golomb escape suffix (bypass) and an optional bypass sign bin.
//   Bins are fetched from the arithmetic decoder one at a time through
//   the request/valid handshake in qdec_tu_egk_fsm_if.
//
//   Ports
//     clk, rst_n    clock, asynchronous active-low reset
//     start         one-cycle pulse, accepted only when idle
//     sign_en       sampled with start: decode a sign bin when value > 0
//     suffix_en     sampled with start: 0 = plain TU, no escape suffix
//     ctx_base      sampled with start: context base for prefix bins
//     flush         synchronous abort to idle, no done pulse
//     bin           handshake to the bin decoder (master modport)
//     busy          high whenever not idle
//     done          one-cycle pulse, abs_val/sign/err valid
//     abs_val       decoded magnitude (saturates to all-ones)
//     sign          1 = negative
//     err           escape overflow, valid with done
//
//   Build option
//     QDEC_EGK_OVF_CHK_EN  when defined, a 1 bin arriving after
//       MAX_EGK_PREFIX escape ones ends the decode with err=1 and a
//       saturated value, and saturation of the result also raises err.
//       When undefined, err is tied 0 and the MAX_EGK_PREFIX-th escape
//       one acts as the unary terminator.
module qdec_tu_egk_fsm #(
  parameter int CMAX           = 5,
  parameter int EGK_K          = 0,
  parameter int MAX_EGK_PREFIX = 16,
  parameter int CTX_LAST       = 1,
  parameter int VAL_W          = 16,
  parameter int CTX_W          = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sign_en,
  input  logic                suffix_en,
  input  logic [CTX_W-1:0]    ctx_base,
  input  logic                flush,
  qdec_tu_egk_fsm_if.master   bin,
  output logic                busy,
  output logic                done,
  output logic [VAL_W-1:0]    abs_val,
  output logic                sign,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFIX, S_SUF_UNARY, S_SUF_FIXED, S_SIGN, S_DONE
  } state_t;

  localparam logic [VAL_W:0] CMAX_X = (VAL_W+1)'(CMAX);

  state_t           state, next_state;
  logic             issue, waiting;
  logic [3:0]       bin_idx;
  logic [5:0]       k;
  logic [4:0]       ones;
  logic [VAL_W:0]   esc, suf;
  logic             sign_en_q, suffix_en_q;
  logic [CTX_W-1:0] ctx_base_q;

  logic             bin_ok, last_prefix, issue_nxt, fin_take;
  logic             unary_ovf, unary_cap;
  logic [VAL_W-1:0] prefix_val, fin_val;
  logic [VAL_W:0]   pow_k, esc_inc, suf_shift, suf_sel, fin_sum;
  logic [CTX_W-1:0] ctx_off;

  // Escape arithmetic is VAL_W+1 bits wide and sticky-saturating, so any
  // intermediate at or above 2^VAL_W still forces a saturated result.
  function automatic logic [VAL_W:0] sat_add(input logic [VAL_W:0] a,
                                             input logic [VAL_W:0] b);
    logic [VAL_W+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[VAL_W+1] ? {(VAL_W+1){1'b1}} : s[VAL_W:0];
  endfunction

  assign bin_ok      = waiting & bin.bin_vld;
  assign last_prefix = (bin_idx == 4'(CMAX-1));
  assign prefix_val  = bin.bin_val ? VAL_W'(CMAX) : VAL_W'(bin_idx);
  assign ctx_off     = (int'(bin_idx) < CTX_LAST) ? CTX_W'(bin_idx) : CTX_W'(CTX_LAST);
  assign pow_k       = (int'(k) > VAL_W) ? {(VAL_W+1){1'b1}}
                                         : ({{VAL_W{1'b0}}, 1'b1} << k);
  assign esc_inc     = sat_add(esc, pow_k);
  assign suf_shift   = suf[VAL_W] ? {(VAL_W+1){1'b1}} : {suf[VAL_W-1:0], bin.bin_val};
  // suf is still zero while in the unary part, so this covers both exits.
  assign suf_sel     = (state == S_SUF_FIXED) ? suf_shift : suf;
  assign fin_sum     = sat_add(sat_add(CMAX_X, esc), suf_sel);
  assign fin_val     = fin_sum[VAL_W] ? {VAL_W{1'b1}} : fin_sum[VAL_W-1:0];
  // The suffix is complete on a 0 unary bin with no fixed bits left, or
  // on the last fixed bit.
  assign fin_take    = bin_ok &&
                       ((state == S_SUF_UNARY && !bin.bin_val && k == '0 && !unary_cap) ||
                        (state == S_SUF_FIXED && k == 6'd1));

`ifdef QDEC_EGK_OVF_CHK_EN
  assign unary_ovf = (ones == 5'(MAX_EGK_PREFIX));
  assign unary_cap = 1'b0;
`else
  assign unary_ovf = 1'b0;
  assign unary_cap = (ones == 5'(MAX_EGK_PREFIX-1));
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; every bin-consuming state advances only on bin_ok.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) next_state = S_PREFIX;
        S_PREFIX:
          if (bin_ok && (!bin.bin_val || last_prefix)) begin
            if (bin.bin_val && suffix_en_q)          next_state = S_SUF_UNARY;
            else if (sign_en_q && prefix_val != '0)  next_state = S_SIGN;
            else                                     next_state = S_DONE;
          end
        S_SUF_UNARY:
          if (bin_ok) begin
            if (bin.bin_val) begin
              if (unary_ovf)      next_state = S_DONE;
              else if (unary_cap) next_state = S_SUF_FIXED;
            end else if (k != '0) begin
              next_state = S_SUF_FIXED;
            end else begin
              next_state = sign_en_q ? S_SIGN : S_DONE;
            end
          end
        S_SUF_FIXED:
          if (bin_ok && k == 6'd1) next_state = sign_en_q ? S_SIGN : S_DONE;
        S_SIGN: if (bin_ok) next_state = S_DONE;
        S_DONE: next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // A new request follows start or each consumed bin whenever the next
  // state still needs a bin, keeping exactly one request outstanding.
  assign issue_nxt = !flush &&
                     (next_state inside {S_PREFIX, S_SUF_UNARY, S_SUF_FIXED, S_SIGN}) &&
                     ((state == S_IDLE && start) || bin_ok);

  // Handshake tracking and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue       <= 1'b0;
      waiting     <= 1'b0;
      bin_idx     <= '0;
      k           <= '0;
      ones        <= '0;
      esc         <= '0;
      suf         <= '0;
      sign_en_q   <= 1'b0;
      suffix_en_q <= 1'b0;
      ctx_base_q  <= '0;
      abs_val     <= '0;
      sign        <= 1'b0;
    end else if (flush) begin
      issue   <= 1'b0;
      waiting <= 1'b0;
    end else begin
      issue   <= issue_nxt;
      waiting <= issue | (waiting & ~bin.bin_vld);
      case (state)
        S_IDLE:
          if (start) begin
            bin_idx     <= '0;
            k           <= 6'(EGK_K);
            ones        <= '0;
            esc         <= '0;
            suf         <= '0;
            sign_en_q   <= sign_en;
            suffix_en_q <= suffix_en;
            ctx_base_q  <= ctx_base;
            abs_val     <= '0;
            sign        <= 1'b0;
          end
        S_PREFIX:
          if (bin_ok) begin
            if (!bin.bin_val || last_prefix) abs_val <= prefix_val;
            else                             bin_idx <= bin_idx + 4'd1;
          end
        S_SUF_UNARY:
          if (bin_ok && bin.bin_val) begin
            if (unary_ovf) begin
              abs_val <= {VAL_W{1'b1}};
            end else begin
              esc  <= esc_inc;
              k    <= k + 6'd1;
              ones <= ones + 5'd1;
            end
          end
        S_SUF_FIXED:
          if (bin_ok) begin
            suf <= suf_shift;
            k   <= k - 6'd1;
          end
        S_SIGN:
          if (bin_ok) sign <= bin.bin_val;
        default: ;
      endcase
      if (fin_take) abs_val <= fin_val;
    end
  end

`ifdef QDEC_EGK_OVF_CHK_EN
  // Error flag: escape-prefix overflow or saturation of the final sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (!flush) begin
      if (state == S_IDLE && start)
        err <= 1'b0;
      else if (bin_ok && state == S_SUF_UNARY && bin.bin_val && unary_ovf)
        err <= 1'b1;
      else if (fin_take)
        err <= fin_sum[VAL_W];
    end
  end
`else
  assign err = 1'b0;
`endif

  // Outputs decoded from state and the request register.
  always_comb begin
    bin.bin_req      = issue;
    bin.bin_bypass   = issue && (state != S_PREFIX);
    bin.bin_ctx_addr = '0;
    if (issue && state == S_PREFIX) bin.bin_ctx_addr = ctx_base_q + ctx_off;
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_qdec_tu_egk_fsm.sv
// tb_qdec_tu_egk_fsm
//   Directed bench for qdec_tu_egk_fsm. A behavioural model turns the bin
//   sequence of each vector into the expected request list, result and
//   latency; a monitor compares every request and every done pulse against
//   it, and each vector also carries a hand-computed result literal.
module tb_qdec_tu_egk_fsm;

  localparam int CMAX = 5, EGK_K = 0, MAXP = 16, CTX_LAST = 1;
  localparam int VAL_W = 16, CTX_W = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, sign_en = 1'b0, suffix_en = 1'b0, flush = 1'b0;
  logic [CTX_W-1:0] ctx_base = '0;
  logic busy, done, sign, err;
  logic [VAL_W-1:0] abs_val;

  qdec_tu_egk_fsm_if #(.CTX_W(CTX_W)) bif ();

  qdec_tu_egk_fsm #(
    .CMAX(CMAX), .EGK_K(EGK_K), .MAX_EGK_PREFIX(MAXP), .CTX_LAST(CTX_LAST),
    .VAL_W(VAL_W), .CTX_W(CTX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign_en(sign_en),
    .suffix_en(suffix_en), .ctx_base(ctx_base), .flush(flush), .bin(bif),
    .busy(busy), .done(done), .abs_val(abs_val), .sign(sign), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int ctx; bit byp; } req_t;

  int     errors = 0, checks = 0, done_count = 0;
  longint cyc = 0, start_cyc = 0, exp_lat = 0, exp_abs = 0;
  bit     exp_sign, exp_err, exp_done_pending = 1'b0;
  int     lat = 1, rsp_cnt = 0;
  bit     stim_bins[$];
  bit     bin_q[$];
  req_t   exp_req_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic bit getBin(input int pos);
    return (pos < stim_bins.size()) ? stim_bins[pos] : 1'b0;
  endfunction

  task automatic addBits(input int count, input bit v);
    for (int i = 0; i < count; i++) stim_bins.push_back(v);
  endtask

  task automatic pushReq(input int ctx, input bit byp);
    req_t r;
    r.ctx = ctx;
    r.byp = byp;
    exp_req_q.push_back(r);
  endtask

  // Reference decode from the binarization rules: count leading ones,
  // escape value 2^K*(2^n-1) plus a (K+n)-bit suffix, then the sign.
  task automatic runModel(input bit se, input bit sfx, input int base);
    int pos, n1, n;
    longint value, suf;
    bit ovf;
    exp_req_q.delete();
    pos = 0; n1 = 0; ovf = 0; exp_err = 0; exp_sign = 0;
    while (n1 < CMAX && getBin(pos)) begin
      pushReq(base + ((n1 < CTX_LAST) ? n1 : CTX_LAST), 1'b0);
      pos++; n1++;
    end
    if (n1 < CMAX) begin
      pushReq(base + ((n1 < CTX_LAST) ? n1 : CTX_LAST), 1'b0);
      pos++;
    end
    value = n1;
    if (n1 == CMAX && sfx) begin
      n = 0;
      forever begin
`ifdef QDEC_EGK_OVF_CHK_EN
        if (n == MAXP && getBin(pos)) begin
          pushReq(-1, 1'b1); pos++; ovf = 1; break;
        end
`endif
        pushReq(-1, 1'b1);
        pos++;
        if (!getBin(pos-1)) break;
        n++;
`ifndef QDEC_EGK_OVF_CHK_EN
        if (n == MAXP) break;
`endif
      end
      if (ovf) begin
        value = longint'(1) << VAL_W;
      end else begin
        suf = 0;
        for (int i = 0; i < EGK_K + n; i++) begin
          pushReq(-1, 1'b1);
          suf = suf * 2 + longint'(getBin(pos));
          pos++;
        end
        value = CMAX + (longint'(1) << EGK_K) * ((longint'(1) << n) - 1) + suf;
      end
      if (value > (longint'(1) << VAL_W) - 1) begin
        value = (longint'(1) << VAL_W) - 1;
`ifdef QDEC_EGK_OVF_CHK_EN
        exp_err = 1;
`endif
      end
    end
    if (se && value > 0 && !ovf) begin
      pushReq(-1, 1'b1);
      exp_sign = getBin(pos);
      pos++;
    end
    exp_abs = value;
    exp_lat = longint'(pos) * (lat + 1) + 1;
  endtask

  // Bin decoder stand-in: answers each request after lat cycles.
  initial begin
    bif.bin_vld = 1'b0;
    bif.bin_val = 1'b0;
    forever begin
      @(negedge clk);
      bif.bin_vld = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bif.bin_vld = 1'b1;
          bif.bin_val = (bin_q.size() > 0) ? bin_q.pop_front() : 1'b0;
        end
      end
      if (bif.bin_req) rsp_cnt = lat;
    end
  end

  // Compare process: every request and every done pulse against the model.
  always @(negedge clk) begin : monitor
    req_t r;
    if (rst_n) begin
      if (bif.bin_req) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_req: got bin_req=1, required 0");
        end else begin
          r = exp_req_q.pop_front();
          checkOutput("req_bypass", bif.bin_bypass, r.byp);
          if (r.ctx >= 0) checkOutput("req_ctx", bif.bin_ctx_addr, r.ctx);
        end
      end
      if (done) begin
        done_count++;
        if (!exp_done_pending) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_done: got done=1, required 0");
        end else begin
          checkOutput("abs_val", abs_val, exp_abs);
          checkOutput("sign", sign, exp_sign);
          checkOutput("err", err, exp_err);
          checkOutput("latency", cyc - start_cyc, exp_lat);
          checkOutput("reqs_left", exp_req_q.size(), 0);
          exp_done_pending = 1'b0;
        end
      end
    end
  end

  task automatic startDecode(input bit se, input bit sfx, input int base, input int lt);
    lat = lt;
    runModel(se, sfx, base);
    bin_q = stim_bins;
    exp_done_pending = 1'b1;
    @(negedge clk);
    sign_en = se; suffix_en = sfx; ctx_base = CTX_W'(base); start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; sign_en = 1'b0; suffix_en = 1'b0; ctx_base = '0;
  endtask

  // One full decode; poke >= 0 pulses a second start (with sign_en=1)
  // that many cycles into the decode, which must be ignored.
  task automatic applyStimulus(input bit se, input bit sfx, input int base, input int lt,
                               input int poke, input longint lit_abs, input bit lit_sign);
    startDecode(se, sfx, base, lt);
    for (int i = 0; i < 3000 && exp_done_pending; i++) begin
      if (i == poke) begin start = 1'b1; sign_en = 1'b1; ctx_base = '1; end
      else begin start = 1'b0; sign_en = 1'b0; ctx_base = '0; end
      @(negedge clk);
    end
    start = 1'b0; sign_en = 1'b0; ctx_base = '0;
    if (exp_done_pending) begin
      checks++; errors++;
      $display("[TB] FAIL timeout: done not seen within 3000 cycles");
      exp_done_pending = 1'b0;
    end
    @(negedge clk);
    checkOutput("lit_abs", abs_val, lit_abs);
    checkOutput("lit_sign", sign, lit_sign);
    checkOutput("idle_busy", busy, 0);
  endtask

  task automatic dropExpectations();
    exp_done_pending = 1'b0;
    exp_req_q.delete();
    bin_q.delete();
  endtask

  task automatic followUp();
    stim_bins.delete(); addBits(1, 1'b1); addBits(1, 1'b0);
    applyStimulus(1'b0, 1'b0, 20, 1, -1, 1, 1'b0);
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    checkOutput("rst_bin_req", bif.bin_req, 0);
    checkOutput("rst_ctx", bif.bin_ctx_addr, 0);
    checkOutput("rst_bypass", bif.bin_bypass, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_abs", abs_val, 0);
    checkOutput("rst_sign", sign, 0);
    checkOutput("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0 bin, sign enabled but value 0: no sign bin.
    stim_bins.delete(); addBits(1, 1'b0);
    applyStimulus(1'b1, 1'b0, 100, 1, -1, 0, 1'b0);

    // Prefix 1,1,0 then sign 1; contexts 200,201,201.
    stim_bins.delete(); addBits(2, 1'b1); addBits(2, 1'b0); stim_bins[3] = 1'b1;
    applyStimulus(1'b1, 1'b0, 200, 2, -1, 2, 1'b1);

    // Escape: 5 ones, unary 1,1,0, fixed 1,0 -> 5+3+2.
    stim_bins.delete(); addBits(7, 1'b1); addBits(1, 1'b0); addBits(1, 1'b1); addBits(1, 1'b0);
    applyStimulus(1'b0, 1'b1, 40, 1, -1, 10, 1'b0);

    // Plain TU at the cap: no suffix bins.
    stim_bins.delete(); addBits(5, 1'b1);
    applyStimulus(1'b0, 1'b0, 60, 3, -1, 5, 1'b0);

    // Escape with an immediate 0 (no fixed bits) then sign 1.
    stim_bins.delete(); addBits(5, 1'b1); addBits(1, 1'b0); addBits(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 70, 1, -1, 5, 1'b1);

    // Long escape: saturates to 0xFFFF in both builds.
    stim_bins.delete(); addBits(5 + 32, 1'b1);
    applyStimulus(1'b0, 1'b1, 80, 1, -1, 65535, 1'b0);
`ifdef QDEC_EGK_OVF_CHK_EN
    checkOutput("sat_err", err, 1);
`else
    checkOutput("sat_err", err, 0);
`endif

    // Reset asserted while in the escape unary part.
    stim_bins.delete(); addBits(15, 1'b1);
    startDecode(1'b0, 1'b1, 50, 1);
    repeat (13) @(negedge clk);
    checkOutput("pre_rst_busy", busy, 1);
    dc = done_count;
    #1 rst_n = 1'b0;
    dropExpectations();
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_abs", abs_val, 0);
    checkOutput("async_rst_req", bif.bin_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rst_no_done", done_count - dc, 0);
    followUp();

    // Flush in the middle of the prefix.
    stim_bins.delete(); addBits(5, 1'b1);
    startDecode(1'b0, 1'b0, 300, 1);
    repeat (3) @(negedge clk);
    checkOutput("pre_flush_busy", busy, 1);
    dc = done_count;
    flush = 1'b1;
    dropExpectations();
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_idle", busy, 0);
    repeat (6) @(negedge clk);
    checkOutput("flush_no_done", done_count - dc, 0);
    followUp();

    // Start pulsed while busy must not restart or resample sign_en.
    stim_bins.delete(); addBits(1, 1'b1); addBits(1, 1'b0);
    applyStimulus(1'b0, 1'b0, 30, 3, 2, 1, 1'b0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
